// File: rtl/ram_1r1w_masked.sv
// One-read/one-write masked RAM with per-entry valid bits and write-to-read forwarding.
// Latency: read data and R0_valid are registered, 1 cycle after the request edge.
// Backpressure: none; every read and write request completes in the cycle it is sampled.
module ram_1r1w_masked #(
    parameter int DEPTH     = 2,
    parameter int WIDTH     = 81,
    parameter int MASK_GRAN = 81,
    localparam int AW       = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
    localparam int NLANES   = WIDTH / MASK_GRAN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AW-1:0]     R0_addr,
    input  logic              R0_en,
    output logic [WIDTH-1:0]  R0_data,
    output logic              R0_valid,
    input  logic [AW-1:0]     W0_addr,
    input  logic              W0_en,
    input  logic [WIDTH-1:0]  W0_data,
    input  logic [NLANES-1:0] W0_mask
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;

    logic             rd_in_range;
    logic             wr_in_range;
    logic             wr_fire;
    logic [WIDTH-1:0] rd_stored;
    logic [WIDTH-1:0] rd_next;

    assign rd_in_range = ({1'b0, R0_addr} < DEPTH_L);
    assign wr_in_range = ({1'b0, W0_addr} < DEPTH_L);
    // An all-zero mask must not mark the entry valid, so it counts as no write at all.
    assign wr_fire     = W0_en && wr_in_range && (|W0_mask);

    // Post-write view of the read address: stored (or zero if never written), overlaid with written lanes.
    always_comb begin
        rd_stored = '0;
        if (rd_in_range && valid[R0_addr]) begin
            rd_stored = mem[R0_addr];
        end
        rd_next = rd_stored;
        if (wr_fire && (W0_addr == R0_addr)) begin
            for (int i = 0; i < NLANES; i++) begin
                if (W0_mask[i]) begin
                    rd_next[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Array contents are deliberately not reset; reset only gates the write enable.
    always_ff @(posedge clock) begin
        if (!reset && wr_fire) begin
            for (int i = 0; i < NLANES; i++) begin
                if (W0_mask[i]) begin
                    mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid    <= '0;
            R0_data  <= '0;
            R0_valid <= 1'b0;
        end else begin
            if (wr_fire) begin
                valid[W0_addr] <= 1'b1;
            end
            R0_valid <= R0_en;
            if (R0_en) begin
                R0_data <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_ram_1r1w_masked.sv
// Directed bench: a 2x81 single-lane instance and a 5x32 byte-lane instance share clock and reset.
module tb_ram_1r1w_masked;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [0:0]  a_raddr = '0;
    logic        a_ren   = 1'b0;
    logic [80:0] a_rdata;
    logic        a_rvalid;
    logic [0:0]  a_waddr = '0;
    logic        a_wen   = 1'b0;
    logic [80:0] a_wdata = '0;
    logic [0:0]  a_wmask = '0;

    logic [2:0]  b_raddr = '0;
    logic        b_ren   = 1'b0;
    logic [31:0] b_rdata;
    logic        b_rvalid;
    logic [2:0]  b_waddr = '0;
    logic        b_wen   = 1'b0;
    logic [31:0] b_wdata = '0;
    logic [3:0]  b_wmask = '0;

    int tests = 0;
    int fails = 0;

    localparam logic [80:0] V81 = 81'h1_2345_6789_ABCD_EF01_2345;

    always #5 clock = ~clock;

    ram_1r1w_masked #(.DEPTH(2), .WIDTH(81), .MASK_GRAN(81)) u_dut_a (
        .clock   (clock),
        .reset   (reset),
        .R0_addr (a_raddr),
        .R0_en   (a_ren),
        .R0_data (a_rdata),
        .R0_valid(a_rvalid),
        .W0_addr (a_waddr),
        .W0_en   (a_wen),
        .W0_data (a_wdata),
        .W0_mask (a_wmask)
    );

    ram_1r1w_masked #(.DEPTH(5), .WIDTH(32), .MASK_GRAN(8)) u_dut_b (
        .clock   (clock),
        .reset   (reset),
        .R0_addr (b_raddr),
        .R0_en   (b_ren),
        .R0_data (b_rdata),
        .R0_valid(b_rvalid),
        .W0_addr (b_waddr),
        .W0_en   (b_wen),
        .W0_data (b_wdata),
        .W0_mask (b_wmask)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [80:0] obs, input logic [80:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic b_write(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] mask);
        b_wen = 1'b1; b_waddr = addr; b_wdata = data; b_wmask = mask;
        tick();
        b_wen = 1'b0;
    endtask

    task automatic b_read(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        b_ren = 1'b1; b_raddr = addr;
        tick();
        b_ren = 1'b0;
        chk({tag, "_vld"}, {80'd0, b_rvalid}, 81'd1);
        chk(tag, {49'd0, b_rdata}, {49'd0, exp});
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_a_data", a_rdata, '0);
        chk("rst_a_vld", {80'd0, a_rvalid}, 81'd0);
        chk("rst_b_data", {49'd0, b_rdata}, '0);
        chk("rst_b_vld", {80'd0, b_rvalid}, 81'd0);
        reset = 1'b0;

        // Unwritten entries read as zero
        a_ren = 1'b1; a_raddr = 1'b0;
        tick();
        chk("t1_rd0_vld", {80'd0, a_rvalid}, 81'd1);
        chk("t1_rd0", a_rdata, '0);
        a_raddr = 1'b1;
        tick();
        chk("t1_rd1_vld", {80'd0, a_rvalid}, 81'd1);
        chk("t1_rd1", a_rdata, '0);
        a_ren = 1'b0;

        // Full-width write, then read; R0_valid must be a single pulse
        a_wen = 1'b1; a_waddr = 1'b1; a_wdata = V81; a_wmask = 1'b1;
        tick();
        chk("t2_wr_novld", {80'd0, a_rvalid}, 81'd0);
        a_wen = 1'b0; a_ren = 1'b1; a_raddr = 1'b1;
        tick();
        chk("t2_rd_vld", {80'd0, a_rvalid}, 81'd1);
        chk("t2_rd", a_rdata, V81);
        a_ren = 1'b0;
        tick();
        chk("t2_pulse", {80'd0, a_rvalid}, 81'd0);
        chk("t2_hold", a_rdata, V81);

        // Lane-masked partial write
        b_write(3'd0, 32'hAABBCCDD, 4'hF);
        b_write(3'd0, 32'h11223344, 4'b0101);
        b_read("t3_lanes", 3'd0, 32'hAA22CC44);

        // Same-address forwarding and different-address independence
        b_write(3'd2, 32'hDEADBEEF, 4'hF);
        b_write(3'd3, 32'h12345678, 4'hF);
        b_wen = 1'b1; b_waddr = 3'd2; b_wdata = 32'h00000055; b_wmask = 4'b0001;
        b_read("t4_fwd", 3'd2, 32'hDEADBE55);
        b_read("t4_after_fwd", 3'd2, 32'hDEADBE55);
        b_wen = 1'b1; b_waddr = 3'd2; b_wdata = 32'hFFFFFFFF; b_wmask = 4'hF;
        b_read("t4_other", 3'd3, 32'h12345678);
        b_read("t4_other_wr", 3'd2, 32'hFFFFFFFF);
        b_wen = 1'b1; b_waddr = 3'd1; b_wdata = 32'h5A5A5AA5; b_wmask = 4'b0001;
        b_read("t4_fwd_inv", 3'd1, 32'h000000A5);

        // Out-of-range and zero-mask writes
        b_write(3'd6, 32'hCAFEF00D, 4'hF);
        b_read("t5_oor_rd", 3'd6, 32'h0);
        b_read("t5_e4_clean", 3'd4, 32'h0);
        b_read("t5_e0_clean", 3'd0, 32'hAA22CC44);
        b_write(3'd4, 32'hFFFFFFFF, 4'h0);
        b_read("t5_mask0", 3'd4, 32'h0);
        b_wen = 1'b1; b_waddr = 3'd7; b_wdata = 32'h77777777; b_wmask = 4'hF;
        b_read("t5_oor_fwd", 3'd7, 32'h0);

        // Asynchronous reset mid-cycle with a write pending
        a_wen = 1'b1; a_waddr = 1'b0; a_wdata = 81'd5; a_wmask = 1'b1;
        tick();
        a_wen = 1'b0; a_ren = 1'b1; a_raddr = 1'b0;
        tick();
        chk("t6_pre", a_rdata, 81'd5);
        a_wen = 1'b1; a_waddr = 1'b1; a_wdata = 81'd9; a_wmask = 1'b1;
        a_raddr = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        chk("t6_async_data", a_rdata, '0);
        chk("t6_async_vld", {80'd0, a_rvalid}, 81'd0);
        tick();
        chk("t6_in_rst_vld", {80'd0, a_rvalid}, 81'd0);
        reset = 1'b0;
        a_wen = 1'b0; a_ren = 1'b1; a_raddr = 1'b0;
        tick();
        chk("t6_rd0_vld", {80'd0, a_rvalid}, 81'd1);
        chk("t6_rd0", a_rdata, '0);
        a_raddr = 1'b1;
        tick();
        chk("t6_rd1", a_rdata, '0);
        a_ren = 1'b0;
        a_wen = 1'b1; a_waddr = 1'b1; a_wdata = 81'd9; a_wmask = 1'b1;
        tick();
        a_wen = 1'b0; a_ren = 1'b1; a_raddr = 1'b1;
        tick();
        chk("t6_rd1_new", a_rdata, 81'd9);
        a_ren = 1'b0;
        tick();
        chk("t6_idle_vld", {80'd0, a_rvalid}, 81'd0);
        chk("t6_idle_hold", a_rdata, 81'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_1r1w_masked.md
Name: ram_1r1w_masked

Overview:
- Parametrised successor to the fixed-size two-entry memory macros.
- One-read/one-write RAM with configurable depth and width, lane write mask, and a registered 1-cycle read.
- Adds same-cycle write-to-read forwarding and per-entry valid tracking, so unwritten entries read as zero after reset.
- Used for small metadata and queue storage in the core, where firtool-style behavioural RAMs need deterministic, X-free read data.

Parameters:
DEPTH, 2, number of entries; must be >= 2; need not be a power of two.
WIDTH, 81, data bits per entry.
MASK_GRAN, 81, bits per write-mask lane; WIDTH must be an exact multiple of MASK_GRAN.
(Derived values, not overridable:)
- AW = max(1, clog2(DEPTH)).
- NLANES = WIDTH/MASK_GRAN.

Ports:
clock  input  1  single clock for all state; rising edge.
reset  input  1  asynchronous, active-high reset.
R0_addr  input  AW  read address.
R0_en  input  1  read request, sampled on the clock edge.
R0_data  output  WIDTH  registered read data.
R0_valid  output  1  high for the one cycle in which R0_data carries the response to a request.
W0_addr  input  AW  write address.
W0_en  input  1  write request, sampled on the clock edge.
W0_data  input  WIDTH  write data.
W0_mask  input  NLANES  per-lane write enable; lane i covers bits [i*MASK_GRAN +: MASK_GRAN].

Behaviour:
- One clock domain, named clock; reset is asynchronous and active-high, named reset.

Reset:
- While reset is high: R0_data = 0, R0_valid = 0, all entry valid bits = 0.
- Array contents are not reset.
- A write or read sampled on an edge while reset is high is discarded.
- Deasserting reset mid-operation requires no further sequencing; the first edge with reset low operates normally.

Write:
- On a rising edge with W0_en = 1 and W0_addr < DEPTH, each lane with W0_mask[i] = 1 is written.
- Unmasked lanes keep their old value.
- valid[W0_addr] is set only if at least one mask bit is 1.
- A write with W0_mask = 0 has no effect.
- W0_addr >= DEPTH: write ignored.

Read:
- Latency is 1 cycle: a request sampled at edge N drives R0_data and R0_valid = 1 after edge N.
- If R0_en = 0 at an edge: R0_valid = 0 and R0_data holds its previous value.
- Back-to-back reads every cycle are supported; throughput is 1 per cycle.
- valid[R0_addr] = 0 or R0_addr >= DEPTH: returned data is all zeros (never X).

Read/write same cycle, same address (forwarding):
- Returned data is the post-write value, per lane:
  - W0_mask[i] = 1: lane = W0_data lane.
  - W0_mask[i] = 0: lane = stored lane, or 0 if the entry was invalid.

Read/write same cycle, different addresses:
- Independent; the read returns the pre-existing contents.

Other:
- No internal state machine beyond the array, valid bits and output registers.
- No backpressure: every request completes.

Test Plan:
1. Reset, then read addr 0 and addr 1 with no prior writes -> R0_valid = 1 one cycle later; R0_data = 0 both times.
2. DEPTH=2, WIDTH=81, MASK_GRAN=81: write addr 1 = 81'h1_2345_6789_ABCD_EF01_2345, then read addr 1 next cycle -> data equals the written value one cycle after the read; R0_valid is a single-cycle pulse.
3. WIDTH=32, MASK_GRAN=8:
   - Write addr 0 = 32'hAABBCCDD, mask 4'hF.
   - Then write addr 0 = 32'h11223344, mask 4'b0101.
   - Then read addr 0 -> 32'hAA22CC44.
4. WIDTH=32, MASK_GRAN=8: addr 2 holds 32'hDEADBEEF. Read and write addr 2 in the same cycle with data 32'h00000055, mask 4'b0001 -> R0_data = 32'hDEADBE55 next cycle. A same-cycle read of addr 3 returns its old contents.
5. DEPTH=5:
   - Write addr 6 (out of range) -> no entry changes.
   - Read addr 6 -> 0, valid = 1.
   - Write mask 0 to addr 4, then read addr 4 -> 0 (entry still invalid).
6. Write addr 0 = 5, then assert reset asynchronously mid-cycle while a write to addr 1 = 9 is pending:
   - R0_data and R0_valid clear immediately.
   - After reset releases, reads of addr 0 and addr 1 return 0.
   - Then idle a cycle with R0_en = 0 -> R0_data holds, R0_valid = 0.
